// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply sequencer. Drives the shared ALU with ADD ops and
// leaves the operand shifting to local registers. The result is the low WIDTH
// bits of the product, plus a sticky overflow flag for the bits that were lost.
module alu_mul_sequencer #(
  parameter int         WIDTH  = 8,
  parameter logic [2:0] ADD_OP = 3'b001,
  parameter logic [2:0] FWD_OP = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [2:0]       alu_select,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_ADD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc, m, q;
  logic             ovf;

  // A shift drops m's MSB. That bit is significant only if a higher multiplier
  // bit is still pending, so it is lost product bits only when q>>1 != 0.
  logic shift_ovf;
  assign shift_ovf = m[WIDTH-1] & (q[WIDTH-1:1] != '0);

  // An ADD carries out exactly when the wrapped sum is smaller than the addend.
  logic add_carry;
  assign add_carry = (alu_result < acc);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and ALU drive; the ALU sees nonzero data only in ADD
  always_comb begin
    state_d    = state_q;
    alu_data1  = '0;
    alu_data2  = '0;
    alu_select = FWD_OP;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (q == '0)    state_d = S_DONE;
        else if (q[0])  state_d = S_ADD;
      end
      S_ADD: begin
        alu_data1  = acc;
        alu_data2  = m;
        alu_select = ADD_OP;
        state_d    = S_EVAL;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Working registers: capture on accept, shift in EVAL/ADD, accumulate in ADD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      m   <= '0;
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc <= '0;
            m   <= operand_a;
            q   <= operand_b;
            ovf <= 1'b0;
          end
        end
        S_EVAL: begin
          if (q != '0 && !q[0]) begin
            m   <= m << 1;
            q   <= q >> 1;
            ovf <= ovf | shift_ovf;
          end
        end
        S_ADD: begin
          acc <= alu_result;
          m   <= m << 1;
          q   <= q >> 1;
          ovf <= ovf | add_carry | shift_ovf;
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the EVAL->DONE edge and hold until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product  <= '0;
      overflow <= 1'b0;
    end else if (state_q == S_EVAL && q == '0) begin
      product  <= acc;
      overflow <= ovf;
    end
  end

endmodule
